vga_scan_gen: RTL



---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/vga_scan_gen_clk_en_div.sv | 22 ++
 rtl/vga_scan_gen.sv | 82 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and count width shared by scan and draw blocks
package vga_timing_pkg;
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  function automatic logic in_win(input cnt_t x, input int lo, input int n);
    return int'(x) >= lo && int'(x) < lo + n;
  endfunction
endpackage

// File: rtl/vga_scan_gen_clk_en_div.sv
// clk_en_div: one-clk enable pulse every CLK_DIV clocks; en_next flags the edge that raises en
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic en,
  output logic en_next
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign en_next = cnt == W'(CLK_DIV - 1);
  // wrap the divider and register the pulse for the clk after the last count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      en <= 1'b0;
    end else begin
      cnt <= en_next ? '0 : cnt + 1'b1;
      en <= en_next;
    end
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster counters, syncs, visible flag and frame pulse; VGA_SCAN_PIPE_EN delays hsync/vsync/valid by one pixel tick
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_DISP = DEF_H_DISP,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pclk_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic             frame_start
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  logic tick;
  cnt_t h_nx, v_nx;
  logic hs_nx, vs_nx, vl_nx, h_wrap;
  logic hs_q, vs_q, vl_q;
  clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .en(pclk_en),
    .en_next(tick)
  );
  // next raster position and the sync/visible flags that describe it
  always_comb begin
    h_wrap = h_cnt == cnt_t'(H_TOTAL - 1);
    h_nx = h_wrap ? '0 : h_cnt + 1'b1;
    v_nx = !h_wrap ? v_cnt : v_cnt == cnt_t'(V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
    hs_nx = !in_win(h_nx, H_DISP + H_FP, H_SYNC);
    vs_nx = !in_win(v_nx, V_DISP + V_FP, V_SYNC);
    vl_nx = int'(h_nx) < H_DISP && int'(v_nx) < V_DISP;
  end
  // reset parks the scan on the last position so the first tick lands on (0,0)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= cnt_t'(H_TOTAL - 1);
      v_cnt <= cnt_t'(V_TOTAL - 1);
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      vl_q <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_nx == '0 && v_nx == '0;
      if (tick) begin
        h_cnt <= h_nx;
        v_cnt <= v_nx;
        hs_q <= hs_nx;
        vs_q <= vs_nx;
        vl_q <= vl_nx;
      end
    end
`ifdef VGA_SCAN_PIPE_EN
  // one pixel-tick lag to line up with the block-RAM read of the pixel address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      valid <= 1'b0;
    end else if (tick) begin
      hsync <= hs_q;
      vsync <= vs_q;
      valid <= vl_q;
    end
`else
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign valid = vl_q;
`endif
endmodule
